// File: rtl/sc_req_arbiter.sv
// sc_req_arbiter: round-robin arbiter that shares the bridge's single sc_*
// request port among NUM_REQ requesters. It runs one transaction at a time
// (grant, issue, wait, respond). A watchdog stops a hung downstream
// transaction from holding the arbiter forever.
module sc_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 40,
  parameter int ID_WIDTH       = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ID_WIDTH-1:0]      req_id,
  input  logic [NUM_REQ*8-1:0]             req_len,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_wstrb,
  output logic                             m_we,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic [7:0]                       m_len,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic                             m_done,
  output logic                             busy,
  output logic [GW-1:0]                    grant_idx
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] last;
  logic [CW-1:0] cnt;
  logic          nxt_found;
  logic [GW-1:0] nxt_grant;
  logic [GW-1:0] cand;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  logic [SW-1:0]         wstrb_a [NUM_REQ];
  logic [ID_WIDTH-1:0]   id_a    [NUM_REQ];
  logic [7:0]            len_a   [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_a[i] = req_wstrb[i*SW +: SW];
    assign id_a[i]    = req_id[i*ID_WIDTH +: ID_WIDTH];
    assign len_a[i]   = req_len[i*8 +: 8];
  end

  assign m_addr  = addr_a[grant_idx];
  assign m_wdata = wdata_a[grant_idx];
  assign m_wstrb = wstrb_a[grant_idx];
  assign m_we    = req_we[grant_idx];
  assign m_id    = id_a[grant_idx];
  assign m_len   = len_a[grant_idx];
  assign m_valid = (state == S_ISSUE);
  assign busy    = (state != S_IDLE);

  // Round-robin search: first asserted requester after the last grant.
  always_comb begin
    nxt_found = 1'b0;
    nxt_grant = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(last) + i) % NUM_REQ);
      if (!nxt_found && req_valid[cand]) begin
        nxt_found = 1'b1;
        nxt_grant = cand;
      end
    end
  end

  // Accept strobe and response pulse steered to the granted requester.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == S_ISSUE && m_ready) req_ready[grant_idx] = 1'b1;
    if (state == S_RESP)             rsp_valid[grant_idx] = 1'b1;
  end

  // Transaction sequencer with saturating completion watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      last      <= GW'(NUM_REQ - 1);
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (nxt_found) begin
            grant_idx <= nxt_grant;
            last      <= nxt_grant;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_ready) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (m_done) begin
            rsp_rdata <= m_rdata;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LIM) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Granted requester must hold its request until accepted.
  a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_ISSUE) |-> req_valid[grant_idx])
    else $error("req_valid dropped while waiting for req_ready");
`endif

endmodule

// File: tb/tb_sc_req_arbiter.sv
// Testbench for sc_req_arbiter: directed vector table, reset/abort sequence,
// then randomized transactions checked against a round-robin reference model.
module tb_sc_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int AW = 40;
  localparam int IW = 12;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*8-1:0]  req_wstrb;
  logic [NR-1:0]    req_we;
  logic [NR*IW-1:0] req_id;
  logic [NR*8-1:0]  req_len;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             m_valid;
  logic             m_ready;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [7:0]       m_wstrb;
  logic             m_we;
  logic [IW-1:0]    m_id;
  logic [7:0]       m_len;
  logic [DW-1:0]    m_rdata;
  logic             m_done;
  logic             busy;
  logic [1:0]       grant_idx;

  sc_req_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_we(req_we),
    .req_id(req_id), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_we(m_we), .m_id(m_id), .m_len(m_len),
    .m_rdata(m_rdata), .m_done(m_done), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester-side state owned by the bench
  logic [3:0]    pend = '0;
  logic          p_we    [NR];
  logic [AW-1:0] p_addr  [NR];
  logic [DW-1:0] p_wdata [NR];
  logic [7:0]    p_wstrb [NR];
  logic [IW-1:0] p_id    [NR];
  logic [7:0]    p_len   [NR];

  // Reference model state
  int            last_m  = NR - 1;
  logic [DW-1:0] hold_rd = '0;
  logic          hold_err = 1'b0;

  typedef struct {
    logic [3:0]    post;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rdy;
    int            done;
    logic [DW-1:0] rdata;
    int            exp_g;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pend[i];
      req_we[i]              = p_we[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_wdata[i];
      req_wstrb[i*8 +: 8]    = p_wstrb[i];
      req_id[i*IW +: IW]     = p_id[i];
      req_len[i*8 +: 8]      = p_len[i];
    end
  endtask

  // Round robin from the rule: first pending requester after the last grant
  function automatic int rr_pick(input int lst, input logic [3:0] m);
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (lst + k) % NR;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_grant_idx"}, grant_idx, 0);
  endtask

  // One full transaction starting in an IDLE cycle
  task automatic run_txn(input logic [3:0] post, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int rdy, input int done,
                         input logic [DW-1:0] rdata, input int eg, input logic eerr,
                         input logic [DW-1:0] erd);
    logic [3:0] oh;
    int nw;
    for (int i = 0; i < NR; i++) begin
      if (post[i] && !pend[i]) begin
        pend[i]    = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = addr;
        p_wdata[i] = wdata;
        p_wstrb[i] = 8'($urandom);
        p_id[i]    = IW'($urandom);
        p_len[i]   = 8'($urandom);
      end
    end
    drive_bus();
    m_ready = 1'b0;
    m_done  = 1'($urandom);
    m_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("rsp_rdata_hold", rsp_rdata, hold_rd);
    chk("rsp_err_hold", rsp_err, hold_err);
    tick();
    oh = 4'b0001 << eg;
    for (int c = 0; c <= rdy; c++) begin
      m_ready = (c == rdy);
      m_done  = 1'($urandom);
      @(negedge clk);
      chk("m_valid", m_valid, 1);
      chk("issue_busy", busy, 1);
      chk("grant_idx", grant_idx, 64'(eg));
      chk("m_addr", m_addr, p_addr[eg]);
      chk("m_wdata", m_wdata, p_wdata[eg]);
      chk("m_wstrb", m_wstrb, p_wstrb[eg]);
      chk("m_we", m_we, p_we[eg]);
      chk("m_id", m_id, p_id[eg]);
      chk("m_len", m_len, p_len[eg]);
      chk("req_ready", req_ready, (c == rdy) ? oh : 4'b0000);
      chk("issue_rsp_valid", rsp_valid, 0);
      tick();
    end
    pend[eg] = 1'b0;
    drive_bus();
    m_ready = 1'b0;
    nw = (done <= TO - 1) ? done : TO - 1;
    for (int j = 0; j <= nw; j++) begin
      m_done  = (j == done);
      m_rdata = (j == done) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      chk("wait_m_valid", m_valid, 0);
      chk("wait_busy", busy, 1);
      chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_req_ready", req_ready, 0);
      tick();
    end
    m_done  = 1'($urandom);
    m_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_err", rsp_err, eerr);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("resp_busy", busy, 1);
    tick();
    m_done   = 1'b0;
    hold_rd  = erd;
    hold_err = eerr;
    last_m   = eg;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        post     we    addr        wdata                rdy done rdata                   g  err  exp_rdata
    tbl[0]  = '{4'b0100, 1'b1, 40'h100, 64'hDEADBEEF,          0,  4,  64'h0,                  2, 1'b0, 64'h0};
    tbl[1]  = '{4'b1000, 1'b0, 40'h200, 64'h0,                 0,  0,  64'h11,                 3, 1'b0, 64'h11};
    tbl[2]  = '{4'b1111, 1'b0, 40'h300, 64'h0,                 0,  0,  64'hA0,                 0, 1'b0, 64'hA0};
    tbl[3]  = '{4'b1111, 1'b0, 40'h310, 64'h0,                 0,  0,  64'hA1,                 1, 1'b0, 64'hA1};
    tbl[4]  = '{4'b1111, 1'b0, 40'h320, 64'h0,                 0,  0,  64'hA2,                 2, 1'b0, 64'hA2};
    tbl[5]  = '{4'b1111, 1'b0, 40'h330, 64'h0,                 0,  0,  64'hA3,                 3, 1'b0, 64'hA3};
    tbl[6]  = '{4'b1111, 1'b0, 40'h340, 64'h0,                 0,  0,  64'hA4,                 0, 1'b0, 64'hA4};
    tbl[7]  = '{4'b0010, 1'b0, 40'h350, 64'h0,                 0,  0,  64'h123456789ABCDEF0,   1, 1'b0, 64'h123456789ABCDEF0};
    tbl[8]  = '{4'b0000, 1'b0, 40'h0,   64'h0,                 0,  100, 64'h5555,              2, 1'b1, 64'h0};
    tbl[9]  = '{4'b0000, 1'b0, 40'h0,   64'h0,                 10, 2,  64'hCAFE,               3, 1'b0, 64'hCAFE};
    tbl[10] = '{4'b0001, 1'b1, 40'h360, 64'h77,                0,  15, 64'hBEEF,               0, 1'b0, 64'hBEEF};

    for (int i = 0; i < NR; i++) begin
      p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      p_wstrb[i] = '0; p_id[i] = '0; p_len[i] = '0;
    end
    rst_n = 1'b0;
    m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 11; t++)
      run_txn(tbl[t].post, tbl[t].we, tbl[t].addr, tbl[t].wdata, tbl[t].rdy, tbl[t].done,
              tbl[t].rdata, tbl[t].exp_g, tbl[t].exp_err, tbl[t].exp_rdata);

    // Reset while requester 1 is in WAIT, then a stray completion
    pend = 4'b0010;
    p_addr[1] = 40'h500; p_we[1] = 1'b0;
    drive_bus();
    m_ready = 1'b1; m_done = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_grant", grant_idx, 1);
    chk("abort_req_ready", req_ready, 4'b0010);
    tick();
    pend = '0;
    drive_bus();
    m_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("abort_in_wait_busy", busy, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    #2 rst_n = 1'b1;
    tick();
    m_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stray_done_rsp_valid", rsp_valid, 0);
      chk("stray_done_busy", busy, 0);
      tick();
    end
    m_done   = 1'b0;
    hold_rd  = '0;
    hold_err = 1'b0;
    last_m   = NR - 1;
    run_txn(4'b0101, 1'b0, 40'h400, 64'h0, 0, 1, 64'h77, 0, 1'b0, 64'h77);

    // Randomized transactions against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [3:0]    post;
      logic [DW-1:0] rd;
      int            d;
      int            eg;
      post = 4'($urandom);
      if ((pend | post) == 4'b0000) post[$urandom_range(0, NR - 1)] = 1'b1;
      eg = rr_pick(last_m, pend | post);
      d  = $urandom_range(0, 20);
      rd = {$urandom, $urandom};
      run_txn(post, 1'($urandom), {8'($urandom), $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), d, rd, eg, (d > TO - 1), (d > TO - 1) ? 64'h0 : rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
